// File: rtl/rpc_config_path_pkg.sv
// Shared types and constants for the maintenance command arbiter:
// source ids, FSM states, grant payload and default busy windows.
package rpc_config_path_pkg;

    localparam int unsigned MAINT_ARB_CMD_WIDTH  = 19;
    localparam int unsigned MAINT_ARB_BUSY_WIDTH = 16;
    localparam int unsigned MAINT_ARB_STAT_WIDTH = 32;

    // Power-on defaults for the tRFC / tZQCS hold-off windows, in clock cycles
    localparam logic [MAINT_ARB_BUSY_WIDTH-1:0] MAINT_ARB_DEFAULT_REF_BUSY = 16'd260;
    localparam logic [MAINT_ARB_BUSY_WIDTH-1:0] MAINT_ARB_DEFAULT_ZQC_BUSY = 16'd64;

    typedef enum logic [1:0] {
        SRC_REF = 2'd0,
        SRC_ZQC = 2'd1,
        SRC_USR = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BLOCK = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic valid;
        src_e src;
    } grant_t;

    // Fixed priority REF > ZQC > USR
    function automatic grant_t prio_grant(input logic ref_v, input logic zqc_v,
                                          input logic usr_v);
        grant_t g;
        g.valid = ref_v | zqc_v | usr_v;
        if (ref_v) begin
            g.src = SRC_REF;
        end else if (zqc_v) begin
            g.src = SRC_ZQC;
        end else begin
            g.src = SRC_USR;
        end
        return g;
    endfunction

endpackage

// File: rtl/maint_busy_counter.sv
// Loadable down-counter with zero / last-cycle flags, timing the tRFC / tZQCS
// hold-off windows after a maintenance command.
module maint_busy_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/maint_cmd_arbiter.sv
// Shares the downstream command channel between REF, ZQC and user commands
// (REF > ZQC > USR) and holds off all grants during the post-maintenance busy
// window. Define MAINT_ARB_STATS_EN to add handshake and USR stall counters.
module maint_cmd_arbiter
    import rpc_config_path_pkg::*;
#(
    parameter int unsigned CMD_WIDTH  = MAINT_ARB_CMD_WIDTH,
    parameter int unsigned BUSY_WIDTH = MAINT_ARB_BUSY_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ref_valid_i,
    input  logic [CMD_WIDTH-1:0]  ref_cmd_i,
    output logic                  ref_ready_o,
    input  logic                  zqc_valid_i,
    input  logic [CMD_WIDTH-1:0]  zqc_cmd_i,
    output logic                  zqc_ready_o,
    input  logic                  usr_valid_i,
    input  logic [CMD_WIDTH-1:0]  usr_cmd_i,
    output logic                  usr_ready_o,
    input  logic [BUSY_WIDTH-1:0] ref_busy_i,
    input  logic [BUSY_WIDTH-1:0] zqc_busy_i,
    output logic                  cmd_valid_o,
    output logic [CMD_WIDTH-1:0]  cmd_o,
    input  logic                  cmd_ready_i,
    output logic                  busy_o
`ifdef MAINT_ARB_STATS_EN
    ,
    output logic [MAINT_ARB_STAT_WIDTH-1:0] ref_cnt_o,
    output logic [MAINT_ARB_STAT_WIDTH-1:0] zqc_cnt_o,
    output logic [MAINT_ARB_STAT_WIDTH-1:0] usr_cnt_o,
    output logic [MAINT_ARB_STAT_WIDTH-1:0] stall_cnt_o
`endif
);

    arb_state_e           state_q, state_d;
    src_e                 src_q, src_d;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                 cmd_valid_q, cmd_valid_d;

    logic                  cnt_load;
    logic [BUSY_WIDTH-1:0] cnt_load_val;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  cnt_last;

    grant_t grant;

    assign grant = prio_grant(ref_valid_i, zqc_valid_i, usr_valid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= SRC_REF;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    // Next state, issue register and same-cycle source grants
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = cmd_valid_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        ref_ready_o  = 1'b0;
        zqc_ready_o  = 1'b0;
        usr_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant.valid) begin
                    cmd_valid_d = 1'b1;
                    src_d       = grant.src;
                    state_d     = ISSUE;
                    case (grant.src)
                        SRC_REF: begin
                            ref_ready_o = 1'b1;
                            cmd_d       = ref_cmd_i;
                        end
                        SRC_ZQC: begin
                            zqc_ready_o = 1'b1;
                            cmd_d       = zqc_cmd_i;
                        end
                        default: begin
                            usr_ready_o = 1'b1;
                            cmd_d       = usr_cmd_i;
                        end
                    endcase
                end
            end

            ISSUE: begin
                if (cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    state_d     = IDLE;
                    // Busy windows are sampled here; a zero window skips BLOCK
                    case (src_q)
                        SRC_REF: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = ref_busy_i;
                            if (ref_busy_i != '0) begin
                                state_d = BLOCK;
                            end
                        end
                        SRC_ZQC: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = zqc_busy_i;
                            if (zqc_busy_i != '0) begin
                                state_d = BLOCK;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end

            BLOCK: begin
                cnt_dec = 1'b1;
                if (cnt_last || cnt_zero) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    maint_busy_counter #(
        .WIDTH (BUSY_WIDTH)
    ) u_busy_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign busy_o      = (state_q == BLOCK);

`ifdef MAINT_ARB_STATS_EN
    logic [MAINT_ARB_STAT_WIDTH-1:0] ref_cnt_q, zqc_cnt_q, usr_cnt_q, stall_cnt_q;
    logic                            dn_hs;

    assign dn_hs = cmd_valid_q && cmd_ready_i;

    // Free-running wrap-around statistics, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ref_cnt_q   <= '0;
            zqc_cnt_q   <= '0;
            usr_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (dn_hs && (src_q == SRC_REF)) begin
                ref_cnt_q <= ref_cnt_q + MAINT_ARB_STAT_WIDTH'(1);
            end
            if (dn_hs && (src_q == SRC_ZQC)) begin
                zqc_cnt_q <= zqc_cnt_q + MAINT_ARB_STAT_WIDTH'(1);
            end
            if (dn_hs && (src_q == SRC_USR)) begin
                usr_cnt_q <= usr_cnt_q + MAINT_ARB_STAT_WIDTH'(1);
            end
            if (usr_valid_i && !usr_ready_o) begin
                stall_cnt_q <= stall_cnt_q + MAINT_ARB_STAT_WIDTH'(1);
            end
        end
    end

    assign ref_cnt_o   = ref_cnt_q;
    assign zqc_cnt_o   = zqc_cnt_q;
    assign usr_cnt_o   = usr_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/maint_cmd_arbiter.md
Name: maint_cmd_arbiter

Overview:
- Shares the single downstream command channel between the refresh timer, the ZQC timer and the user (frontend) command stream.
- Fixed priority: REF > ZQC > USR.
- After a maintenance command is accepted downstream, all grants are held off for a programmable busy window (tRFC / tZQCS), so the DRAM is never addressed while it is busy.
- Sits between the timers/frontend and the PHY command encoder.

Parameters:
- CMD_WIDTH, 19, width of every command bus.
- BUSY_WIDTH, 16, width of the busy-window counter and config inputs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ref_valid_i  in  1  refresh timer command valid
- ref_cmd_i  in  CMD_WIDTH  refresh command
- ref_ready_o  out  1  refresh command taken
- zqc_valid_i  in  1  ZQC timer command valid
- zqc_cmd_i  in  CMD_WIDTH  ZQC command
- zqc_ready_o  out  1  ZQC command taken
- usr_valid_i  in  1  user command valid
- usr_cmd_i  in  CMD_WIDTH  user command
- usr_ready_o  out  1  user command taken
- ref_busy_i  in  BUSY_WIDTH  hold-off cycles after REF (quasi-static)
- zqc_busy_i  in  BUSY_WIDTH  hold-off cycles after ZQC (quasi-static)
- cmd_valid_o  out  1  downstream valid
- cmd_o  out  CMD_WIDTH  downstream command (registered)
- cmd_ready_i  in  1  downstream ready
- busy_o  out  1  high in BLOCK state

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- Reset values: state IDLE; cmd_valid_o=0; cmd_o=0; busy counter=0; all *_ready_o=0; busy_o=0.
- FSM states: IDLE, ISSUE, BLOCK.
- IDLE:
  - Winner is the highest-priority asserted valid.
  - The winner's *_ready_o=1 combinationally in that same cycle; only one ready is ever high.
  - Next edge: cmd_o <= winner cmd; cmd_valid_o <= 1; src_q <= winner id; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - cmd_valid_o=1; cmd_o is stable until cmd_ready_i. All *_ready_o=0.
  - On cmd_ready_i: cmd_valid_o <= 0.
    - src_q=REF: load counter with ref_busy_i.
    - src_q=ZQC: load counter with zqc_busy_i.
    - If the loaded value is nonzero, go to BLOCK; otherwise go to IDLE.
    - src_q=USR: always go to IDLE.
- BLOCK:
  - busy_o=1. No grants; all ready outputs 0.
  - Counter decrements each cycle. Exit to IDLE on the edge where counter==1 is decremented to 0.
  - Busy value N gives exactly N cycles in BLOCK.
- Throughput and latency:
  - Source handshake to cmd_valid_o: 1 cycle.
  - Minimum spacing between grants: 2 cycles (IDLE→ISSUE→IDLE). No grant is made in the same cycle as a downstream handshake.
- Sampling of inputs:
  - Valids change mid-ISSUE/BLOCK: ignored; sampled only in IDLE.
  - Sources must keep valid high until ready (timers already do this).
  - ref_busy_i / zqc_busy_i are sampled only at the ISSUE handshake.
- Simultaneous events:
  - REF and ZQC both valid in IDLE: REF wins. ZQC stays pending and wins at the next IDLE after the REF busy window.
  - USR is served only when neither maintenance source is valid; USR starvation is bounded by the timer intervals.
- Reset mid-operation:
  - Asserting rst_ni low in any state returns to IDLE immediately, drops cmd_valid_o and clears the counter.
  - No partial command is held.
- Default branch: an illegal state goes to IDLE.

Optional Feature:
- Macro: MAINT_ARB_STATS_EN.
- When defined:
  - Adds outputs ref_cnt_o, zqc_cnt_o, usr_cnt_o (32 bit each) and stall_cnt_o (32 bit).
  - Each *_cnt_o increments on a downstream handshake of that source.
  - stall_cnt_o increments each cycle usr_valid_i=1 and usr_ready_o=0.
  - All counters reset to 0, wrap at 2^32, and are cleared by rst_ni only.
- When undefined: these ports and registers do not exist; the remaining behaviour is identical.

Decomposition:
- Package rpc_config_path_pkg holds:
  - src_e enum {SRC_REF, SRC_ZQC, SRC_USR} (2 bit);
  - arb_state_e {IDLE, ISSUE, BLOCK};
  - MAINT_ARB_DEFAULT_REF_BUSY / _ZQC_BUSY constants.
- One sub-module, maint_busy_counter: a loadable down-counter with a zero flag, reused for the tRFC/tZQCS windows.
- Priority encode and FSM stay in the top.

Test Plan:
- Only usr_valid_i=1, cmd=19'h1234, cmd_ready_i=1:
  - usr_ready_o pulses in IDLE cycles;
  - cmd_valid_o=1, cmd_o=19'h1234 one cycle later;
  - grants spaced every 2 cycles; busy_o never 1.
- REF, ZQC and USR all valid in the same cycle, ref_busy_i=10, zqc_busy_i=4:
  - order is REF, then 10 cycles of busy_o, then ZQC, then 4 busy cycles, then USR.
- Backpressure: cmd_ready_i=0 for 7 cycles during a ZQC command:
  - cmd_o and cmd_valid_o stay stable all 7 cycles;
  - no source ready is asserted;
  - the BLOCK window starts only after the handshake.
- ref_busy_i=0:
  - after the REF handshake, the FSM goes directly to IDLE;
  - a pending USR is granted next cycle.
- Assert rst_ni low in BLOCK with the counter at 5:
  - cmd_valid_o=0, busy_o=0 immediately;
  - after release, a valid USR is granted in the first IDLE cycle.
- With MAINT_ARB_STATS_EN: 3 REF, 2 ZQC, 5 USR handshakes:
  - ref_cnt_o=3, zqc_cnt_o=2, usr_cnt_o=5;
  - stall_cnt_o equals the counted USR wait cycles.
